byte_data_memory: RTL and testbench

BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

---
 rtl/byte_data_memory.sv | 175 +++++++++++++++++
 tb/tb_byte_data_memory.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// Word-organised data memory with byte/half/word access, fixed response latency
// and a valid/ready request/response handshake.
module byte_data_memory #(
    parameter int unsigned SIZE    = 128,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] address,
    input  logic [31:0] dataWrite,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] dataRead,
    output logic        respError
);

    localparam int unsigned IW = $clog2(SIZE);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic          unsigned_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          ready_q;
    logic          valid_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem_q [SIZE] = '{default: 32'h0};

    logic          accept_c;
    logic          enter_resp_c;
    logic          cur_write_c;
    logic [1:0]    cur_size_c;
    logic          cur_unsigned_c;
    logic [31:0]   cur_addr_c;
    logic [31:0]   cur_wdata_c;
    logic [IW-1:0] cur_idx_c;
    logic [4:0]    sh_c;
    logic [31:0]   rd_word_c;
    logic [7:0]    rd_byte_c;
    logic [15:0]   rd_half_c;
    logic [31:0]   mask_c;
    logic [31:0]   merged_c;
    logic [31:0]   load_c;
    logic          err_c;
    logic [31:0]   resp_data_c;

    // In IDLE the live inputs are the request being accepted; afterwards the captured copy.
    always_comb begin
        accept_c     = (state_q == IDLE) && reqValid && ready_q;
        enter_resp_c = (accept_c && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q == CW'(1)));
        if (state_q == IDLE) begin
            cur_write_c    = reqWrite;
            cur_size_c     = reqSize;
            cur_unsigned_c = reqUnsigned;
            cur_addr_c     = address;
            cur_wdata_c    = dataWrite;
        end else begin
            cur_write_c    = write_q;
            cur_size_c     = size_q;
            cur_unsigned_c = unsigned_q;
            cur_addr_c     = addr_q;
            cur_wdata_c    = wdata_q;
        end
    end

    always_comb begin
        cur_idx_c = cur_addr_c[IW+1:2];
        sh_c      = {cur_addr_c[1:0], 3'b000};
        rd_word_c = mem_q[cur_idx_c];
        rd_byte_c = rd_word_c[sh_c +: 8];
        rd_half_c = rd_word_c[{cur_addr_c[1], 4'b0000} +: 16];

        err_c = (cur_size_c == 2'b11) ||
                ((cur_size_c == 2'b01) && cur_addr_c[0]) ||
                ((cur_size_c == 2'b10) && (cur_addr_c[1:0] != 2'b00)) ||
                (cur_addr_c[31:2] >= 30'(SIZE));

        mask_c = 32'hFFFF_FFFF;
        load_c = rd_word_c;
        case (cur_size_c)
            2'b00: begin
                mask_c = 32'h0000_00FF << sh_c;
                load_c = cur_unsigned_c ? {24'h0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
            end
            2'b01: begin
                mask_c = 32'h0000_FFFF << sh_c;
                load_c = cur_unsigned_c ? {16'h0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
            end
            default: ;
        endcase
        merged_c    = (rd_word_c & ~mask_c) | ((cur_wdata_c << sh_c) & mask_c);
        resp_data_c = (cur_write_c || err_c) ? 32'h0 : load_c;
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp_c && cur_write_c && !err_c) begin
            mem_q[cur_idx_c] <= merged_c;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        write_q    <= reqWrite;
                        size_q     <= reqSize;
                        unsigned_q <= reqUnsigned;
                        addr_q     <= address;
                        wdata_q    <= dataWrite;
                        ready_q    <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                            rdata_q <= resp_data_c;
                            err_q   <= err_c;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        rdata_q <= resp_data_c;
                        err_q   <= err_c;
                    end
                end
                RESP: begin
                    if (respReady) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reqReady  = ready_q;
    assign respValid = valid_q;
    assign dataRead  = rdata_q;
    assign respError = err_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: one instance at LATENCY=1 and one at LATENCY=4,
// table-driven requests checked through an expected-response queue.
module tb_byte_data_memory;

    typedef struct {
        logic        sel;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1 = 1'b0, rst4 = 1'b0;
    logic        sel = 1'b0;
    logic        t_valid = 1'b0, t_write = 1'b0, t_uns = 1'b0, t_rready = 1'b0;
    logic [1:0]  t_size = 2'b00;
    logic [31:0] t_addr = '0, t_wdata = '0;

    logic        rdy1, rdy4, vld1, vld4, err1, err4;
    logic [31:0] dat1, dat4;
    logic        rdy, vld, err;
    logic [31:0] dat;

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    byte_data_memory #(.SIZE(128), .LATENCY(1)) dut1 (
        .clk(clk), .resetN(rst1), .reqValid(t_valid && !sel), .reqReady(rdy1),
        .reqWrite(t_write), .reqSize(t_size), .reqUnsigned(t_uns), .address(t_addr),
        .dataWrite(t_wdata), .respValid(vld1), .respReady(t_rready),
        .dataRead(dat1), .respError(err1));

    byte_data_memory #(.SIZE(128), .LATENCY(4)) dut4 (
        .clk(clk), .resetN(rst4), .reqValid(t_valid && sel), .reqReady(rdy4),
        .reqWrite(t_write), .reqSize(t_size), .reqUnsigned(t_uns), .address(t_addr),
        .dataWrite(t_wdata), .respValid(vld4), .respReady(t_rready),
        .dataRead(dat4), .respError(err4));

    assign rdy = sel ? rdy4 : rdy1;
    assign vld = sel ? vld4 : vld1;
    assign err = sel ? err4 : err1;
    assign dat = sel ? dat4 : dat1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic w, input logic [1:0] z, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] ed, input logic ee);
        vec_t v;
        v.sel = s; v.wr = w; v.sz = z; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Present one request, wait for acceptance, then scramble the inputs.
    task automatic issue(input vec_t v);
        int n = 0;
        exp_t e;
        sel = v.sel;
        #1;
        while (!rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_req", 32'(rdy), 32'd1);
        t_write = v.wr; t_size = v.sz; t_uns = v.uns; t_addr = v.addr; t_wdata = v.wdata;
        t_valid = 1'b1;
        e.data = v.exp_data; e.err = v.exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        t_valid = 1'b0;
        t_write = 1'($urandom); t_size = 2'($urandom); t_uns = 1'($urandom);
        t_addr = $urandom; t_wdata = $urandom;
    endtask

    // Called right after issue(): measure latency, compare, hold, handshake.
    task automatic collect(input int hold);
        int n = 1;
        int lat = sel ? 4 : 1;
        exp_t e;
        while (!vld && n < 30) begin
            check("ready_low_wait", 32'(rdy), 32'd0);
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(lat));
        if (!vld) return;
        e = sb.pop_front();
        check("dataRead", dat, e.data);
        check("respError", 32'(err), 32'(e.err));
        check("ready_low_resp", 32'(rdy), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(vld), 32'd1);
            check("hold_data", dat, e.data);
            check("hold_err", 32'(err), 32'(e.err));
            check("hold_ready", 32'(rdy), 32'd0);
        end
        t_rready = 1'b1;
        @(posedge clk); #1;
        t_rready = 1'b0;
        check("valid_cleared", 32'(vld), 32'd0);
        check("ready_after_hs", 32'(rdy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        check({tag, "_valid"}, 32'(vld), 32'd0);
        check({tag, "_data"}, dat, 32'h0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        // LATENCY=1 functional vectors
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 2'b00, 0, 32'h13,  32'h12345680, 32'h0,        0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFF80, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 32'h13,  32'h0,        32'h00000080, 0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10,  32'h0,        32'h80ADBEEF, 0));
        tbl.push_back(mk(0, 0, 2'b01, 0, 32'h11,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h202, 32'h11111111, 32'h0,        1));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h200, 32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1, 2'b01, 0, 32'h12,  32'hAAAA8001, 32'h0,        0));
        tbl.push_back(mk(0, 0, 2'b10, 1, 32'h10,  32'h0,        32'h8001BEEF, 0));
        tbl.push_back(mk(0, 0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFF8001, 0));
        tbl.push_back(mk(0, 0, 2'b01, 1, 32'h12,  32'h0,        32'h00008001, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 32'h11,  32'h0,        32'hFFFFFFBE, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 32'h10,  32'h0,        32'h000000EF, 0));
        tbl.push_back(mk(0, 1, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h11,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1, 2'b00, 0, 32'h8000_0010, 32'h55, 32'h0,        1));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10,  32'h0,        32'h8001BEEF, 0));
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h1FC, 32'h0BADF00D, 32'h0,        0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h1FC, 32'h0,        32'h0BADF00D, 0));
        // LATENCY=4 vectors
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h24,  32'hCAFEF00D, 32'h0,        0));
        tbl.push_back(mk(1, 0, 2'b01, 0, 32'h26,  32'h0,        32'hFFFFCAFE, 0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 32'h25,  32'h0,        32'h000000F0, 0));

        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; #1; check_reset_outputs("rst1");
        sel = 1'b1; #1; check_reset_outputs("rst4");
        rst1 = 1'b1; rst4 = 1'b1;

        foreach (tbl[i]) begin
            issue(tbl[i]);
            collect(0);
        end

        // Response held off for three cycles
        issue(mk(1, 0, 2'b10, 0, 32'h24, 32'h0, 32'hCAFEF00D, 0));
        collect(3);

        // Reset during WAIT discards the pending store
        issue(mk(1, 1, 2'b10, 0, 32'h20, 32'h12345678, 32'h0, 0));
        @(posedge clk); #1;
        rst4 = 1'b0; #1;
        check_reset_outputs("rst_wait");
        void'(sb.pop_back());
        repeat (6) @(posedge clk);
        #1;
        check("rst_wait_no_resp", 32'(vld), 32'd0);
        rst4 = 1'b1;
        issue(mk(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h00000000, 0));
        collect(0);

        // Reset during RESP drops the response but keeps the committed store
        issue(mk(0, 1, 2'b10, 0, 32'h30, 32'h55AA55AA, 32'h0, 0));
        check("rst_resp_valid", 32'(vld), 32'd1);
        void'(sb.pop_back());
        rst1 = 1'b0; #1;
        check_reset_outputs("rst_resp");
        #2 rst1 = 1'b1;
        @(posedge clk); #1;
        issue(mk(0, 0, 2'b10, 0, 32'h30, 32'h0, 32'h55AA55AA, 0));
        collect(0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
